key_provision_ctrl: RTL

Serial key loader that sits beside a locked combinational benchmark core (XOR key gates plus 4-bit mux key).
- Accepts a key stream bit by bit over a valid/ready handshake and checks it with a trailing CRC-8.
- On a clean check, drives the full key vector (XOR key bits and mux selects) to the locked core in one atomic update.
- Holds the key at zero whenever no verified key is present.

---
 rtl/key_prov_pkg.sv | 24 ++
 rtl/crc8_serial.sv | 28 ++
 rtl/key_provision_ctrl.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/key_prov_pkg.sv
// Shared constants, widths and FSM state type for the serial key provisioning controller.
// Optional lockout (KEY_PROV_LOCKOUT_EN) adds the LOCKED state.
package key_prov_pkg;

    localparam int XOR_KEY_W   = 40;
    localparam int MUX_KEY_W   = 4;
    localparam int KEY_W       = XOR_KEY_W + MUX_KEY_W;
    localparam int CRC_W       = 8;
    localparam logic [CRC_W-1:0] CRC_POLY = 8'h07;
    localparam int LOCK_THRESH = 3;
    localparam int CNT_W       = $clog2(KEY_W + CRC_W);

    typedef enum logic [2:0] {
        IDLE,
        SHIFT,
        CHECK,
        ACTIVE
`ifdef KEY_PROV_LOCKOUT_EN
        ,
        LOCKED
`endif
    } state_t;

endpackage

// File: rtl/crc8_serial.sv
// Bit-serial CRC-8 (non-reflected, init 0), one message bit per enabled cycle.
// Latency: remainder reflects a bit one edge after it is enabled; never stalls.
module crc8_serial
    import key_prov_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic             din,
    output logic [CRC_W-1:0] crc
);

    logic fb;

    assign fb = crc[CRC_W-1] ^ din;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            crc <= '0;
        end else if (clr) begin
            crc <= '0;
        end else if (en) begin
            crc <= {crc[CRC_W-2:0], 1'b0} ^ (fb ? CRC_POLY : '0);
        end
    end

endmodule

// File: rtl/key_provision_ctrl.sv
// Serial key loader: shifts in key+CRC-8, commits the key atomically on a clean check (KEY_PROV_LOCKOUT_EN adds fail lockout).
// Latency: key_valid rises on the second edge after the last bit is accepted; sin_ready is high only while shifting.
module key_provision_ctrl
    import key_prov_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             clear,
    input  logic             sin_valid,
    input  logic             sin_data,
    output logic             sin_ready,
    output logic [KEY_W-1:0] key_out,
    output logic             key_valid,
    output logic             busy,
    output logic             err
);

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(KEY_W + CRC_W - 1);
    localparam logic [CNT_W-1:0] KEY_END  = CNT_W'(KEY_W);

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic [KEY_W-1:0]   sreg;
    logic [CRC_W-1:0]   crc;
    logic               accept, restart, zeroize, commit, fail;
`ifdef KEY_PROV_LOCKOUT_EN
    logic [1:0]         fail_cnt;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        restart   = 1'b0;
        zeroize   = 1'b0;
        commit    = 1'b0;
        fail      = 1'b0;
`ifdef KEY_PROV_LOCKOUT_EN
        if (clear && state != LOCKED) begin
`else
        if (clear) begin
`endif
            zeroize   = 1'b1;
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE, ACTIVE: begin
                    if (start) begin
                        restart   = 1'b1;
                        state_nxt = SHIFT;
                    end
                end
                SHIFT: begin
                    if (start) begin
                        restart = 1'b1;
                    end else if (sin_valid) begin
                        accept = 1'b1;
                        if (cnt == LAST_IDX) begin
                            state_nxt = CHECK;
                        end
                    end
                end
                CHECK: begin
                    if (crc == '0) begin
                        commit    = 1'b1;
                        state_nxt = ACTIVE;
                    end else begin
                        fail      = 1'b1;
                        state_nxt = IDLE;
`ifdef KEY_PROV_LOCKOUT_EN
                        if (fail_cnt == 2'(LOCK_THRESH - 1)) begin
                            state_nxt = LOCKED;
                        end
`endif
                    end
                end
`ifdef KEY_PROV_LOCKOUT_EN
                LOCKED: state_nxt = LOCKED;
`endif
                default: state_nxt = IDLE;
            endcase
        end
    end

    assign sin_ready = (state == SHIFT);
    assign busy      = (state == SHIFT) || (state == CHECK);

    // key_out only ever moves on a verified commit or a zeroize; shifting stays internal.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt       <= '0;
            sreg      <= '0;
            key_out   <= '0;
            key_valid <= 1'b0;
            err       <= 1'b0;
        end else begin
            if (zeroize || restart) begin
                cnt       <= '0;
                key_out   <= '0;
                key_valid <= 1'b0;
                err       <= 1'b0;
            end
            if (restart) begin
                sreg <= '0;
            end
            if (accept) begin
                cnt <= cnt + CNT_W'(1);
                if (cnt < KEY_END) begin
                    sreg <= {sreg[KEY_W-2:0], sin_data};
                end
            end
            if (commit) begin
                key_out   <= sreg;
                key_valid <= 1'b1;
            end
            if (fail) begin
                err <= 1'b1;
            end
        end
    end

`ifdef KEY_PROV_LOCKOUT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fail_cnt <= '0;
        end else if (commit) begin
            fail_cnt <= '0;
        end else if (fail && fail_cnt != 2'd3) begin
            fail_cnt <= fail_cnt + 2'd1;
        end
    end
`endif

    crc8_serial u_crc (
        .clk (clk),
        .rst (rst),
        .clr (restart || zeroize),
        .en  (accept),
        .din (sin_data),
        .crc (crc)
    );

endmodule
